hs_sync_sink: RTL and testbench

Synchronous sink stage that terminates the four-phase bundled-data handshake driven by the resilient token controller (its `Rreq` output) and hands tokens into the clocked domain. It synchronises the incoming request, captures the bundled data and the two timing-error flags (Err1/Err0) that travel with each token, returns the acknowledge, and buffers tokens in a small FIFO with a valid/ready output. It also keeps a saturating count of tokens that arrived with an error flag set.

---
 rtl/hs_sync_sink_if.sv | 28 ++
 rtl/hs_sync_sink.sv | 189 ++++++++++++++++++
 tb/tb_hs_sync_sink.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_sync_sink_if.sv
// Bundle of the four-phase upstream handshake, the valid/ready token output
// and the error-count/status signals of the synchronous sink stage.
interface hs_sync_sink_if #(
    parameter int WIDTH = 8
);
    logic             Lreq;
    logic             Lack;
    logic [WIDTH-1:0] Ldata;
    logic [1:0]       Lerr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_err;
    logic [15:0]      err_count;
    logic             err_clr;
    logic             full;
    logic             empty;

    modport master (
        output Lreq, Ldata, Lerr, out_ready, err_clr,
        input  Lack, out_valid, out_data, out_err, err_count, full, empty
    );

    modport slave (
        input  Lreq, Ldata, Lerr, out_ready, err_clr,
        output Lack, out_valid, out_data, out_err, err_count, full, empty
    );
endinterface

// File: rtl/hs_sync_sink.sv
// Sink for a four-phase bundled-data handshake: synchronises Lreq, captures
// data plus Err1/Err0, acknowledges, and buffers tokens in a valid/ready FIFO.
module hs_sync_sink #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic          clk,
    input logic          rst,
    hs_sync_sink_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(SYNC_STAGES + 1);
    localparam int EW = WIDTH + 2;

    typedef enum logic [1:0] {
        RSTWAIT = 2'd0,
        IDLE    = 2'd1,
        ACK     = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SW-1:0]          r_settle;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_lack;
    logic                   w_lack_nxt;
    logic                   w_capture;
    logic                   w_req_s;
    logic                   w_settled;

    logic                   r_wr_vld_p0;
    logic [EW-1:0]          r_wr_data_p0;

    logic [EW-1:0]          r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   w_write;
    logic                   w_read;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_out_valid;
    logic [EW-1:0]          w_head;

    logic [15:0]            r_err_cnt;
    logic                   w_err_hit;

    // ---- stage: request synchroniser ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.Lreq};
        end
    end

    assign w_req_s = r_sync[SYNC_STAGES-1];

    // The synchroniser is cleared by reset, so req_s only reflects the live
    // Lreq after it has refilled; a request held across reset must not look low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle <= '0;
        end else if (r_state == RSTWAIT && !w_settled) begin
            r_settle <= r_settle + 1'b1;
        end
    end

    assign w_settled = (r_settle == SW'(SYNC_STAGES));

    // ---- stage: handshake FSM ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RSTWAIT;
            r_lack  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lack  <= w_lack_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lack_nxt  = r_lack;
        w_capture   = 1'b0;
        case (r_state)
            RSTWAIT: begin
                w_lack_nxt = 1'b0;
                if (w_settled && !w_req_s) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                w_lack_nxt = 1'b0;
                if (w_req_s && !w_full) begin
                    w_capture   = 1'b1;
                    w_lack_nxt  = 1'b1;
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                if (!w_req_s) begin
                    w_lack_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_lack_nxt  = 1'b0;
                w_state_nxt = RSTWAIT;
            end
        endcase
    end

    // ---- stage p0: captured token waiting for its FIFO write ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_vld_p0 <= 1'b0;
        end else begin
            r_wr_vld_p0 <= w_capture;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_wr_data_p0 <= {bus.Lerr, bus.Ldata};
        end
    end

    // ---- stage: FIFO ----
    // A new capture needs a full req_s low/high cycle, so the pending p0 write
    // always lands before the FSM samples full again.
    assign w_write     = r_wr_vld_p0;
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_out_valid = !w_empty;
    assign w_read      = w_out_valid && bus.out_ready;
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= r_wr_data_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_read) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_write, w_read})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---- stage: error counter ----
    assign w_err_hit = w_write && (r_wr_data_p0[EW-1 -: 2] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst || bus.err_clr) begin
            r_err_cnt <= '0;
        end else if (w_err_hit) begin
            r_err_cnt <= sat_inc(r_err_cnt);
        end
    end

    assign bus.Lack      = r_lack;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? w_head[WIDTH-1:0] : '0;
    assign bus.out_err   = w_out_valid ? w_head[EW-1 -: 2] : 2'b00;
    assign bus.err_count = r_err_cnt;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
endmodule

// File: tb/tb_hs_sync_sink.sv
// Bench for hs_sync_sink: upstream handshake driver, token consumer and a
// queue-based model of the token stream and saturating error count.
module tb_hs_sync_sink;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [W+1:0] model_q[$];
    int           model_err = 0;

    hs_sync_sink_if #(.WIDTH(W)) bus ();

    hs_sync_sink #(.WIDTH(W), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic model_push(input logic [W-1:0] d, input logic [1:0] e);
        model_q.push_back({e, d});
        if (e != 2'b00 && model_err < 65535) model_err++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.Lreq = 1'b0;
        bus.Ldata = '0;
        bus.Lerr = 2'b00;
        bus.out_ready = 1'b0;
        bus.err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        model_err = 0;
    endtask

    // Raises Lreq and counts edges until Lack rises; lat = -1 on timeout.
    task automatic raise_req(input logic [W-1:0] d, input logic [1:0] e,
                             input int budget, output int lat);
        bus.Ldata = d;
        bus.Lerr = e;
        bus.Lreq = 1'b1;
        lat = 0;
        while (bus.Lack !== 1'b1 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        if (bus.Lack !== 1'b1) lat = -1;
    endtask

    task automatic lower_req(input int budget, output int lat);
        bus.Lreq = 1'b0;
        lat = 0;
        while (bus.Lack !== 1'b0 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        if (bus.Lack !== 1'b0) lat = -1;
    endtask

    task automatic pop_one(output logic [W+1:0] got, output bit ok);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.out_valid === 1'b1);
        got = {bus.out_err, bus.out_data};
        if (ok) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.Lack, bus.out_valid, bus.out_data, bus.out_err} !== '0) begin
            errors++;
            $display("FAIL reset_outs: got Lack=%b valid=%b data=%h err=%b required all 0",
                     bus.Lack, bus.out_valid, bus.out_data, bus.out_err);
        end
        checks++;
        if (bus.err_count !== 16'h0 || bus.full !== 1'b0 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: got cnt=%h full=%b empty=%b required 0000/0/1",
                     bus.err_count, bus.full, bus.empty);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        logic [W+1:0] got;
        bit ok;
        raise_req(8'hA5, 2'b00, 20, n);
        model_push(8'hA5, 2'b00);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL single_ack_rise: got latency %0d required 3", n);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.out_err !== 2'b00) begin
            errors++;
            $display("FAIL single_out: got valid=%b data=%h err=%b required 1/a5/00",
                     bus.out_valid, bus.out_data, bus.out_err);
        end
        lower_req(20, n);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL single_ack_fall: got latency %0d required 3", n);
        end
        checks++;
        if (bus.err_count !== 16'(model_err)) begin
            errors++;
            $display("FAIL single_errcnt: got %0d required %0d", bus.err_count, model_err);
        end
        pop_one(got, ok);
        checks++;
        if (!ok || got !== model_q.pop_front()) begin
            errors++;
            $display("FAIL single_pop: got %h ok=%0d", got, ok);
        end
    endtask

    task automatic test_fill();
        int n;
        logic [W+1:0] got;
        logic [W+1:0] exp;
        bit ok;
        for (int i = 1; i <= 4; i++) begin
            raise_req(W'(i), 2'b00, 20, n);
            checks++;
            if (n != 3) begin
                errors++;
                $display("FAIL fill_ack%0d: got latency %0d required 3", i, n);
            end
            model_push(W'(i), 2'b00);
            lower_req(20, n);
        end
        checks++;
        if (bus.full !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: got %b required 1", bus.full);
        end
        raise_req(8'h05, 2'b00, 15, n);
        checks++;
        if (n != -1) begin
            errors++;
            $display("FAIL fill_backpressure: got ack after %0d required none", n);
        end
        pop_one(got, ok);
        exp = model_q.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL fill_pop1: got %h required %h", got, exp);
        end
        n = 0;
        while (bus.Lack !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.Lack !== 1'b1) begin
            errors++;
            $display("FAIL fill_ack5: got Lack=%b required 1 after room", bus.Lack);
        end
        model_push(8'h05, 2'b00);
        lower_req(20, n);
        while (model_q.size() > 0) begin
            exp = model_q.pop_front();
            pop_one(got, ok);
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL fill_drain: got %h required %h", got, exp);
            end
        end
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL fill_empty: got %b required 1", bus.empty);
        end
    endtask

    task automatic test_errors();
        int n;
        logic [W+1:0] got;
        logic [W+1:0] exp;
        logic [1:0] flags [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        bit ok;
        for (int i = 0; i < 4; i++) begin
            raise_req(W'($urandom), flags[i], 20, n);
            model_push(bus.Ldata, flags[i]);
            lower_req(20, n);
        end
        checks++;
        if (bus.err_count !== 16'd3) begin
            errors++;
            $display("FAIL err_count3: got %0d required 3", bus.err_count);
        end
        for (int i = 0; i < 4; i++) begin
            exp = model_q.pop_front();
            pop_one(got, ok);
            checks++;
            if (!ok || got[W+1:W] !== flags[i] || got !== exp) begin
                errors++;
                $display("FAIL err_seq%0d: got %h required %h", i, got, exp);
            end
        end
        // err_clr held across the capture and write edges of an error token
        bus.Ldata = W'($urandom);
        bus.Lerr = 2'b11;
        bus.Lreq = 1'b1;
        repeat (2) @(negedge clk);
        bus.err_clr = 1'b1;
        repeat (2) @(negedge clk);
        bus.err_clr = 1'b0;
        model_push(bus.Ldata, 2'b11);
        model_err = 0;
        lower_req(20, n);
        checks++;
        if (bus.err_count !== 16'(model_err)) begin
            errors++;
            $display("FAIL err_clr_prio: got %0d required %0d", bus.err_count, model_err);
        end
        exp = model_q.pop_front();
        pop_one(got, ok);
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL err_clr_token: got %h required %h", got, exp);
        end
    endtask

    task automatic test_saturation();
        int n;
        logic [W+1:0] got;
        bit ok;
        @(negedge clk);
        force dut.r_err_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.r_err_cnt;
        model_err = 65534;
        for (int i = 0; i < 2; i++) begin
            logic [1:0] e = 2'($urandom_range(1, 3));
            raise_req(W'($urandom), e, 20, n);
            model_push(bus.Ldata, e);
            lower_req(20, n);
            checks++;
            if (bus.err_count !== 16'(model_err)) begin
                errors++;
                $display("FAIL sat_%0d: got %h required %h", i, bus.err_count, model_err);
            end
        end
        while (model_q.size() > 0) begin
            void'(model_q.pop_front());
            pop_one(got, ok);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int seen = 0;
        logic [W+1:0] got;
        logic [W+1:0] exp;
        bit ok;
        raise_req(8'h11, 2'b00, 20, n);
        lower_req(20, n);
        raise_req(8'h22, 2'b01, 20, n);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        model_err = 0;
        checks++;
        if (bus.Lack !== 1'b0 || bus.empty !== 1'b1 || bus.err_count !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_clear: got Lack=%b empty=%b cnt=%h required 0/1/0",
                     bus.Lack, bus.empty, bus.err_count);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.Lack !== 1'b0 || bus.out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rstmid_nocapture: got %0d active cycles required 0", seen);
        end
        bus.Lreq = 1'b0;
        repeat (6) @(negedge clk);
        raise_req(8'h33, 2'b10, 20, n);
        model_push(8'h33, 2'b10);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL rstmid_newack: got latency %0d required 3", n);
        end
        lower_req(20, n);
        exp = model_q.pop_front();
        pop_one(got, ok);
        checks++;
        if (!ok || got !== exp || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_token: got %h empty=%b required %h empty=1", got, bus.empty, exp);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [W+1:0] got;
        logic [W+1:0] exp;
        logic [W-1:0] d3;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            raise_req(W'($urandom), 2'b00, 20, n);
            model_push(bus.Ldata, 2'b00);
            lower_req(20, n);
        end
        d3 = W'($urandom);
        bus.Ldata = d3;
        bus.Lerr = 2'b00;
        bus.Lreq = 1'b1;
        repeat (3) @(negedge clk);
        exp = model_q.pop_front();
        got = {bus.out_err, bus.out_data};
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        model_push(d3, 2'b00);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL simul_read: got %h required %h", got, exp);
        end
        checks++;
        if (bus.full !== 1'b0 || bus.out_valid !== 1'b1 || {bus.out_err, bus.out_data} !== model_q[0]) begin
            errors++;
            $display("FAIL simul_state: got full=%b valid=%b head=%h required 0/1/%h",
                     bus.full, bus.out_valid, {bus.out_err, bus.out_data}, model_q[0]);
        end
        lower_req(20, n);
        while (model_q.size() > 0) begin
            exp = model_q.pop_front();
            pop_one(got, ok);
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL simul_drain: got %h required %h", got, exp);
            end
        end
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL simul_count: got empty=%b required 1 after two pops", bus.empty);
        end
    endtask

    task automatic test_random();
        int n;
        int cyc;
        logic [W+1:0] exp;
        for (int r = 0; r < 6; r++) begin
            int k = $urandom_range(1, 4);
            for (int i = 0; i < k; i++) begin
                logic [1:0] e = 2'($urandom);
                raise_req(W'($urandom), e, 20, n);
                checks++;
                if (n != 3) begin
                    errors++;
                    $display("FAIL rand_ack: got latency %0d required 3", n);
                end
                model_push(bus.Ldata, e);
                lower_req(20, n);
            end
            cyc = 0;
            while (model_q.size() > 0 && cyc < 200) begin
                bus.out_ready = 1'($urandom);
                if (bus.out_ready && bus.out_valid === 1'b1) begin
                    exp = model_q.pop_front();
                    checks++;
                    if ({bus.out_err, bus.out_data} !== exp) begin
                        errors++;
                        $display("FAIL rand_data: got %h required %h", {bus.out_err, bus.out_data}, exp);
                    end
                end
                @(negedge clk);
                cyc++;
            end
            bus.out_ready = 1'b0;
            checks++;
            if (model_q.size() != 0 || bus.empty !== 1'b1) begin
                errors++;
                $display("FAIL rand_drain: got %0d left empty=%b required 0/1", model_q.size(), bus.empty);
            end
            checks++;
            if (bus.err_count !== 16'(model_err)) begin
                errors++;
                $display("FAIL rand_errcnt: got %0d required %0d", bus.err_count, model_err);
            end
        end
    endtask

    initial begin
        bus.Lreq = 1'b0;
        bus.Ldata = '0;
        bus.Lerr = 2'b00;
        bus.out_ready = 1'b0;
        bus.err_clr = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_errors();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
